// File: rtl/axis_s2mm_pkg.sv
// Shared types and constants for the S2MM frame arbiter.
// Sizing helper derives the beat count of one block.
package axis_s2mm_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 16;
  localparam int BEAT_W     = 8;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  function automatic int words_per_block(
    input int bytes,
    input int dw
  );
    return bytes / (dw / 8);
  endfunction

endpackage

// File: rtl/axis_frame_len_chk.sv
// Per-frame beat counter flagging short/long frames.
// Emits a single-cycle err pulse per detected violation.
module axis_frame_len_chk
  import axis_s2mm_pkg::*;
#(
  parameter int WORDS = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic hs_i,
  input  logic tlast_i,
  input  logic abort_i,
  output logic err_o
);

  localparam logic [BEAT_W-1:0] LAST_IDX =
    BEAT_W'(WORDS - 1);
  localparam logic [BEAT_W-1:0] SAT = '1;

  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              ovr_q, ovr_d;

  always_comb begin
    beat_d = beat_q;
    ovr_d  = ovr_q;
    err_o  = 1'b0;
    if (abort_i) begin
      beat_d = '0;
      ovr_d  = 1'b0;
    end else if (hs_i) begin
      if (tlast_i) begin
        err_o  = (beat_q != LAST_IDX);
        beat_d = '0;
        ovr_d  = 1'b0;
      end else begin
        // overrun reported once, even when saturated
        if (beat_q == LAST_IDX && !ovr_q) begin
          err_o = 1'b1;
          ovr_d = 1'b1;
        end
        if (beat_q != SAT) begin
          beat_d = beat_q + BEAT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_q <= '0;
      ovr_q  <= 1'b0;
    end else begin
      beat_q <= beat_d;
      ovr_q  <= ovr_d;
    end
  end

endmodule

// File: rtl/axis_s2mm_frame_arb.sv
// Frame-granular round-robin 2:1 AXI-Stream arbiter for S2MM.
// Grants change only on TLAST; tracks frame counts and length errors.
module axis_s2mm_frame_arb
  import axis_s2mm_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEF,
  parameter int BYTES_PER_BLOCK = 64,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                s2mm_prmry_resetn,
  input  logic [DATA_W-1:0]   s0_tdata,
  input  logic [DATA_W/8-1:0] s0_tkeep,
  input  logic                s0_tvalid,
  input  logic                s0_tlast,
  output logic                s0_tready,
  input  logic [DATA_W-1:0]   s1_tdata,
  input  logic [DATA_W/8-1:0] s1_tkeep,
  input  logic                s1_tvalid,
  input  logic                s1_tlast,
  output logic                s1_tready,
  output logic [DATA_W-1:0]   m_tdata,
  output logic [DATA_W/8-1:0] m_tkeep,
  output logic                m_tvalid,
  output logic                m_tlast,
  input  logic                m_tready,
  input  logic [1:0]          src_en,
  input  logic                stat_clr,
  output logic                busy,
  output logic                grant,
  output logic [CNT_W-1:0]    frame_cnt0,
  output logic [CNT_W-1:0]    frame_cnt1,
  output logic [1:0]          len_err
);

  localparam int WORDS =
    words_per_block(BYTES_PER_BLOCK, DATA_W);

  state_e           state_q, state_d;
  logic             grant_q, grant_d;
  logic [CNT_W-1:0] cnt0_q, cnt1_q;
  logic [1:0]       err_q;
  logic [1:0]       cand;
  logic             run;
  logic             hs;
  logic             last_hs;
  logic             chk_err;
  logic             chk_abort;

  assign run  = s2mm_prmry_resetn;
  assign cand = src_en & {s1_tvalid, s0_tvalid}
              & {2{run}};

  always_comb begin
    m_tdata   = grant_q ? s1_tdata  : s0_tdata;
    m_tkeep   = grant_q ? s1_tkeep  : s0_tkeep;
    m_tlast   = grant_q ? s1_tlast  : s0_tlast;
    m_tvalid  = 1'b0;
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    if (state_q == BUSY) begin
      m_tvalid  = grant_q ? s1_tvalid : s0_tvalid;
      s0_tready = ~grant_q & m_tready;
      s1_tready =  grant_q & m_tready;
    end
    // gating is combinational so the stream stops this cycle
    if (!run || areset) begin
      m_tvalid  = 1'b0;
      s0_tready = 1'b0;
      s1_tready = 1'b0;
    end
  end

  assign hs      = m_tvalid & m_tready;
  assign last_hs = hs & m_tlast;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          (&cand): begin
            grant_d = ~grant_q;
            state_d = BUSY;
          end
          (cand == 2'b01): begin
            grant_d = 1'b0;
            state_d = BUSY;
          end
          (cand == 2'b10): begin
            grant_d = 1'b1;
            state_d = BUSY;
          end
          default: ;
        endcase
      end
      BUSY: begin
        if (last_hs) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (!run) begin
      state_d = IDLE;
    end
  end

  assign chk_abort = ~run | (state_q == IDLE);

  axis_frame_len_chk #(
    .WORDS (WORDS)
  ) u_len_chk (
    .clk_i   (aclk),
    .rst_i   (areset),
    .hs_i    (hs),
    .tlast_i (m_tlast),
    .abort_i (chk_abort),
    .err_o   (chk_err)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      grant_q <= 1'b1;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      if (stat_clr) begin
        cnt0_q <= '0;
        cnt1_q <= '0;
        err_q  <= '0;
      end else begin
        if (last_hs && !grant_q) begin
          cnt0_q <= cnt0_q + CNT_W'(1);
        end
        if (last_hs && grant_q) begin
          cnt1_q <= cnt1_q + CNT_W'(1);
        end
        if (chk_err) begin
          err_q[grant_q] <= 1'b1;
        end
      end
    end
  end

  assign busy       = (state_q == BUSY);
  assign grant      = grant_q;
  assign frame_cnt0 = cnt0_q;
  assign frame_cnt1 = cnt1_q;
  assign len_err    = err_q;

endmodule

// File: doc/axis_s2mm_frame_arb.md
Name: axis_s2mm_frame_arb

Overview:
Frame-granular 2:1 AXI-Stream arbiter in front of the S2MM DMA write channel. Shares the single S2MM stream between source 0 (test-pattern generator) and source 1 (sample datapath). Grants switch only on TLAST boundaries, using round-robin. The block also gates all traffic on the S2MM run indication, checks every frame against the configured block length, and keeps per-source frame counters for software.

Parameters:
DATA_W, 32, stream data width in bits
BYTES_PER_BLOCK, 64, expected frame length in bytes; WORDS_PER_BLOCK = BYTES_PER_BLOCK/(DATA_W/8), range 1..256
CNT_W, 16, width of each per-source frame counter

Ports:
aclk  in  1  clock
areset  in  1  synchronous, active-high reset
s2mm_prmry_resetn  in  1  1 = S2MM channel running; 0 = gate all traffic
s0_tdata  in  DATA_W  source 0 data
s0_tkeep  in  DATA_W/8  source 0 keep
s0_tvalid  in  1  source 0 valid
s0_tlast  in  1  source 0 last
s0_tready  out  1  source 0 ready
s1_tdata, s1_tkeep, s1_tvalid, s1_tlast, s1_tready  as for s0, source 1
m_tdata  out  DATA_W  to S2MM
m_tkeep  out  DATA_W/8  to S2MM
m_tvalid  out  1  to S2MM
m_tlast  out  1  to S2MM
m_tready  in  1  from S2MM
src_en  in  2  per-source enable; sampled only in IDLE
stat_clr  in  1  single-cycle pulse; clears counters and error flags
busy  out  1  frame in progress
grant  out  1  currently/last granted source
frame_cnt0  out  CNT_W  completed frames, source 0
frame_cnt1  out  CNT_W  completed frames, source 1
len_err  out  2  sticky per-source length error

Behaviour:
- Reset (areset=1 at a clock edge):
  - state=IDLE; grant=1, so source 0 wins the first tie.
  - busy=0, beat_cnt=0, frame_cnt0/1=0, len_err=0.
  - m_tvalid=0, s0_tready=0, s1_tready=0.
- States are IDLE and BUSY.
- IDLE:
  - Candidate i = src_en[i] & si_tvalid & s2mm_prmry_resetn.
  - One candidate: grant it. Two candidates: grant ~grant (round-robin).
  - On grant: grant is registered, beat_cnt=0, next state is BUSY. Grant decision costs one cycle.
  - All s*_tready=0 and m_tvalid=0 in IDLE.
- BUSY passthrough is combinational from the granted source:
  - m_tdata, m_tkeep and m_tlast mux from the granted source.
  - m_tvalid = granted si_tvalid.
  - Granted si_tready = m_tready; the other source's tready = 0.
  - m_tdata, m_tkeep and m_tlast are don't-care while m_tvalid=0.
- Handshake hs = m_tvalid & m_tready.
  - hs with tlast=0: beat_cnt++ (saturates at 255).
  - hs with tlast=1: frame_cnt[grant]++ (wraps modulo 2^CNT_W); state goes to IDLE, giving one bubble cycle between frames.
- Length check:
  - At a tlast hs, if beat_cnt != WORDS_PER_BLOCK-1, set len_err[grant].
  - At a non-last hs with beat_cnt == WORDS_PER_BLOCK-1 (overrun), set len_err[grant] once.
  - The frame is still forwarded unchanged in both cases. Arbitration never inserts or forces TLAST.
- s2mm_prmry_resetn=0 in any state:
  - Next state is IDLE and beat_cnt=0.
  - m_tvalid and all s*_tready are forced to 0 combinationally in the same cycle.
  - The aborted frame is not counted and sets no len_err.
- busy = (state==BUSY).
- src_en deasserted mid-frame has no effect until the frame completes.
- stat_clr:
  - Zeroes frame_cnt0/1 and len_err on the next edge.
  - If a counting or error event occurs in the same cycle, clear wins.
- areset mid-frame: immediate return to reset values; stream output drops the same cycle areset is sampled.

Decomposition:
- Shared package axis_s2mm_pkg:
  - State enum (IDLE, BUSY).
  - Function computing WORDS_PER_BLOCK from BYTES_PER_BLOCK and DATA_W.
  - Default DATA_W and CNT_W constants.
- One natural sub-module: axis_frame_len_chk.
  - Contains the beat counter and the early/overrun compare.
  - Inputs: hs, tlast, abort. Output: err pulse.
  - Instantiated once; its err pulse is routed to len_err[grant].

Test Plan:
- Only s0 valid with 16-beat frames, m_tready=1 → frames of 16 beats with TLAST on beat 15; 1 idle cycle between frames; frame_cnt0=3 after 3 frames; len_err=0.
- Both sources continuously valid, 16-beat frames → grants alternate 0,1,0,1 per frame; after 4 frames frame_cnt0=2 and frame_cnt1=2; s1_tready=0 throughout s0 frames.
- Random m_tready backpressure (50%) during an s1 frame → every beat forwarded exactly once, in order, with data and TLAST matching the source; the s1 beat count stays 16.
- s0 sends a 10-beat frame, then a 20-beat frame → len_err=2'b01 after the first frame; it stays set through the second; both frames are forwarded intact; stat_clr pulse → len_err=0 and frame_cnt0=0.
- s2mm_prmry_resetn dropped at beat 5 of an s0 frame → m_tvalid=0 and s0_tready=0 in the same cycle; busy=0 next cycle; frame_cnt0 unchanged; after re-enable, the next grant restarts with beat_cnt=0.
- src_en=2'b10 with both sources valid → only s1 is granted; src_en cleared mid-frame → the current frame completes, then the block stays IDLE.
